// File: rtl/puf_eval_ctrl_if.sv
// Request/response handshake bundle for the arbiter-PUF evaluation controller.
//   req_valid/req_ready/req_challenge : challenge request channel
//   resp_valid/resp_ready             : response handshake
//   resp_bit/resp_ones                : majority-voted bit and count of 1 samples
// master = requester/consumer side, slave = controller side.
interface puf_eval_ctrl_if #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = 3
);
    logic          req_valid;
    logic          req_ready;
    logic [N-1:0]  req_challenge;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_bit;
    logic [CW-1:0] resp_ones;

    modport master (
        output req_valid,
        output req_challenge,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_bit,
        input  resp_ones
    );

    modport slave (
        input  req_valid,
        input  req_challenge,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_bit,
        output resp_ones
    );
endinterface

// File: rtl/puf_eval_ctrl.sv
// Arbiter-PUF evaluation controller: accepts a challenge, runs REPEAT
// clear/settle/sample evaluations on the PUF core and returns the
// majority-voted response bit together with the count of 1 samples.
//   clk, reset     : rising-edge clock, asynchronous active-high reset
//   bus (slave)    : request/response handshake (see puf_eval_ctrl_if)
//   puf_challenge  : registered challenge driven to the PUF core
//   puf_reset      : clear pulse to the PUF core
//   puf_start      : launch level to the PUF core
//   puf_out        : PUF response, asynchronous to clk
//   busy           : high whenever the controller is not idle
module puf_eval_ctrl #(
    parameter int unsigned N             = 8,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned REPEAT        = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    puf_eval_ctrl_if.slave       bus,
    output logic [N-1:0]         puf_challenge,
    output logic                 puf_reset,
    output logic                 puf_start,
    input  logic                 puf_out,
    output logic                 busy
);

    localparam int unsigned CW    = $clog2(REPEAT + 1);
    localparam int unsigned CYC_W = $clog2(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t             state;
    state_t             next_state;

    logic [CYC_W-1:0]   cyc;
    logic [CYC_W-1:0]   cyc_nxt;
    logic [CW-1:0]      rep;
    logic [CW-1:0]      rep_nxt;
    logic [CW-1:0]      ones;
    logic [CW-1:0]      ones_nxt;
    logic [N-1:0]       chal_nxt;

    logic [1:0]         sync;
    logic               puf_sync;

    logic               puf_reset_nxt;
    logic               puf_start_nxt;
    logic               resp_valid_nxt;
    logic               resp_bit_nxt;
    logic [CW-1:0]      resp_ones_nxt;
    logic               req_ready_nxt;
    logic               busy_nxt;

    logic               resp_valid_q;
    logic               resp_bit_q;
    logic [CW-1:0]      resp_ones_q;
    logic               req_ready_q;

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_bit   = resp_bit_q;
    assign bus.resp_ones  = resp_ones_q;
    assign bus.req_ready  = req_ready_q;

    // Two-flop synchronizer for the asynchronous PUF response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], puf_out};
        end
    end

    assign puf_sync = sync[1];

    // State register plus evaluation counters and captured challenge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cyc           <= '0;
            rep           <= '0;
            ones          <= '0;
            puf_challenge <= '0;
        end else begin
            state         <= next_state;
            cyc           <= cyc_nxt;
            rep           <= rep_nxt;
            ones          <= ones_nxt;
            puf_challenge <= chal_nxt;
        end
    end

    // Next-state logic and counter/challenge updates
    always_comb begin
        next_state = state;
        cyc_nxt    = cyc;
        rep_nxt    = rep;
        ones_nxt   = ones;
        chal_nxt   = puf_challenge;
        case (state)
            IDLE: begin
                // req_ready is high exactly while in IDLE
                if (bus.req_valid) begin
                    next_state = CLEAR;
                    cyc_nxt    = '0;
                    rep_nxt    = '0;
                    ones_nxt   = '0;
                    chal_nxt   = bus.req_challenge;
                end
            end
            CLEAR: begin
                if (cyc == CYC_W'(1)) begin
                    next_state = SETTLE;
                    cyc_nxt    = '0;
                end else begin
                    cyc_nxt = cyc + CYC_W'(1);
                end
            end
            SETTLE: begin
                if (cyc == CYC_W'(SETTLE_CYCLES - 1)) begin
                    next_state = SAMPLE;
                    cyc_nxt    = '0;
                end else begin
                    cyc_nxt = cyc + CYC_W'(1);
                end
            end
            SAMPLE: begin
                ones_nxt = ones + CW'(puf_sync);
                rep_nxt  = rep + CW'(1);
                cyc_nxt  = '0;
                // Returning to CLEAR drops puf_start so the next launch is a fresh edge
                next_state = (rep_nxt == CW'(REPEAT)) ? RESP : CLEAR;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output is a flop aligned with state
    always_comb begin
        puf_reset_nxt  = 1'b0;
        puf_start_nxt  = 1'b0;
        resp_valid_nxt = 1'b0;
        resp_bit_nxt   = resp_bit_q;
        resp_ones_nxt  = resp_ones_q;
        req_ready_nxt  = (next_state == IDLE);
        busy_nxt       = (next_state != IDLE);
        case (next_state)
            CLEAR:   puf_reset_nxt  = 1'b1;
            SETTLE:  puf_start_nxt  = 1'b1;
            SAMPLE:  puf_start_nxt  = 1'b1;
            RESP:    resp_valid_nxt = 1'b1;
            default: ;
        endcase
        // Response fields load once on entry to RESP and hold through the handshake
        if (state == SAMPLE && next_state == RESP) begin
            resp_bit_nxt  = (ones_nxt > CW'(REPEAT / 2));
            resp_ones_nxt = ones_nxt;
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            puf_reset    <= 1'b0;
            puf_start    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_bit_q   <= 1'b0;
            resp_ones_q  <= '0;
            req_ready_q  <= 1'b1;
            busy         <= 1'b0;
        end else begin
            puf_reset    <= puf_reset_nxt;
            puf_start    <= puf_start_nxt;
            resp_valid_q <= resp_valid_nxt;
            resp_bit_q   <= resp_bit_nxt;
            resp_ones_q  <= resp_ones_nxt;
            req_ready_q  <= req_ready_nxt;
            busy         <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Directed testbench for puf_eval_ctrl: one instance with the default
// configuration (N=8, SETTLE_CYCLES=16, REPEAT=7) and one with
// REPEAT=1, SETTLE_CYCLES=4. Inputs change #1 after the rising edge and
// outputs are sampled at that same point.
module tb_puf_eval_ctrl;
    timeunit 1ns;
    timeprecision 1ps;

    localparam int unsigned EVAL_A = 19;   // SETTLE_CYCLES + 3
    localparam int unsigned LAT_A  = 133;  // 7 * 19
    localparam int unsigned LAT_B  = 7;    // 1 * (4 + 3)

    logic       clk;
    logic       reset;

    logic [7:0] puf_challenge_a;
    logic       puf_reset_a;
    logic       puf_start_a;
    logic       puf_out_a;
    logic       busy_a;

    logic [7:0] puf_challenge_b;
    logic       puf_reset_b;
    logic       puf_start_b;
    logic       puf_out_b;
    logic       busy_b;

    int n_cmp;
    int n_err;

    // Launch-edge monitor state for instance A
    logic st_prev;
    logic rs_p1, rs_p2, rs_p3;
    int   rises;
    int   bad_pre;

    puf_eval_ctrl_if #(.N(8), .CW(3)) bus_a ();
    puf_eval_ctrl_if #(.N(8), .CW(1)) bus_b ();

    puf_eval_ctrl #(.N(8), .SETTLE_CYCLES(16), .REPEAT(7)) dut_a (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus_a),
        .puf_challenge (puf_challenge_a),
        .puf_reset     (puf_reset_a),
        .puf_start     (puf_start_a),
        .puf_out       (puf_out_a),
        .busy          (busy_a)
    );

    puf_eval_ctrl #(.N(8), .SETTLE_CYCLES(4), .REPEAT(1)) dut_b (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus_b),
        .puf_challenge (puf_challenge_b),
        .puf_reset     (puf_reset_b),
        .puf_start     (puf_start_b),
        .puf_out       (puf_out_b),
        .busy          (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count puf_start rising edges and whether each follows exactly two puf_reset cycles
    initial begin
        st_prev = 1'b0;
        rs_p1   = 1'b0;
        rs_p2   = 1'b0;
        rs_p3   = 1'b0;
        rises   = 0;
        bad_pre = 0;
    end

    always @(negedge clk) begin
        if (puf_start_a && !st_prev) begin
            rises <= rises + 1;
            if (!(rs_p1 && rs_p2 && !rs_p3)) begin
                bad_pre <= bad_pre + 1;
            end
        end
        st_prev <= puf_start_a;
        rs_p3   <= rs_p2;
        rs_p2   <= rs_p1;
        rs_p1   <= puf_reset_a;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept a challenge on A, drive puf_out per evaluation from pat, wait for resp_valid
    task automatic run_eval(input string tag, input logic [7:0] chal, input logic [6:0] pat,
                            input bit inject, input int exp_ones, input bit exp_bit);
        int n;
        int chal_bad;
        int r0;
        int b0;
        r0       = rises;
        b0       = bad_pre;
        chal_bad = 0;
        check({tag, " req_ready before accept"}, 32'(bus_a.req_ready), 32'd1);
        bus_a.req_challenge = chal;
        bus_a.req_valid     = 1'b1;
        @(posedge clk);
        #1;
        bus_a.req_valid     = 1'b0;
        bus_a.req_challenge = ~chal;
        check({tag, " busy after accept"}, 32'(busy_a), 32'd1);
        n = 0;
        while (!bus_a.resp_valid && n < 300) begin
            if (n % EVAL_A == 0 && n / EVAL_A < 7) begin
                puf_out_a = pat[n / EVAL_A];
            end
            if (inject && n == 5) begin
                bus_a.req_challenge = 8'h3C;
                bus_a.req_valid     = 1'b1;
            end
            if (inject && n == 6) begin
                bus_a.req_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
            if (puf_challenge_a !== chal) chal_bad++;
        end
        check({tag, " latency"}, 32'(n), 32'(LAT_A));
        check({tag, " resp_ones"}, 32'(bus_a.resp_ones), 32'(exp_ones));
        check({tag, " resp_bit"}, 32'(bus_a.resp_bit), 32'(exp_bit));
        check({tag, " challenge held"}, 32'(chal_bad), 32'd0);
        check({tag, " launch edges"}, 32'(rises - r0), 32'd7);
        check({tag, " clear before launch"}, 32'(bad_pre - b0), 32'd0);
    endtask

    task automatic handshake_a(input string tag);
        bus_a.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_a.resp_ready = 1'b0;
        check({tag, " resp_valid dropped"}, 32'(bus_a.resp_valid), 32'd0);
        check({tag, " req_ready after handshake"}, 32'(bus_a.req_ready), 32'd1);
        check({tag, " busy after handshake"}, 32'(busy_a), 32'd0);
    endtask

    initial begin
        int n;
        int unstable;
        logic       hold_bit;
        logic [2:0] hold_ones;

        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        puf_out_a = 1'b0;
        puf_out_b = 1'b1;
        bus_a.req_valid     = 1'b0;
        bus_a.req_challenge = 8'h00;
        bus_a.resp_ready    = 1'b0;
        bus_b.req_valid     = 1'b0;
        bus_b.req_challenge = 8'h00;
        bus_b.resp_ready    = 1'b0;

        // Reset values while reset is held
        repeat (3) @(posedge clk);
        #1;
        check("reset puf_challenge", 32'(puf_challenge_a), 32'h0);
        check("reset puf_reset", 32'(puf_reset_a), 32'd0);
        check("reset puf_start", 32'(puf_start_a), 32'd0);
        check("reset resp_valid", 32'(bus_a.resp_valid), 32'd0);
        check("reset resp_bit", 32'(bus_a.resp_bit), 32'd0);
        check("reset resp_ones", 32'(bus_a.resp_ones), 32'd0);
        check("reset req_ready", 32'(bus_a.req_ready), 32'd1);
        check("reset busy", 32'(busy_a), 32'd0);

        // Scenario 1: puf_out always 1, first accept on the first edge after release
        @(negedge clk);
        reset = 1'b0;
        run_eval("s1", 8'hA5, 7'b1111111, 1'b0, 7, 1'b1);
        check("s1 puf_start low in RESP", 32'(puf_start_a), 32'd0);
        check("s1 puf_reset low in RESP", 32'(puf_reset_a), 32'd0);

        // Scenario 3: response held stable while resp_ready stays low
        hold_bit  = bus_a.resp_bit;
        hold_ones = bus_a.resp_ones;
        unstable  = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus_a.resp_valid !== 1'b1 || bus_a.resp_bit !== hold_bit ||
                bus_a.resp_ones !== hold_ones || bus_a.req_ready !== 1'b0) begin
                unstable++;
            end
        end
        check("s3 stalled response stable", 32'(unstable), 32'd0);
        handshake_a("s3");

        // Scenarios 2 and 4: 3 of 7 ones, plus an ignored request during SETTLE
        run_eval("s2", 8'h5A, 7'b1000101, 1'b1, 3, 1'b0);
        handshake_a("s2");

        // Majority boundary: 4 of 7 ones votes 1
        run_eval("maj4", 8'h81, 7'b0001111, 1'b0, 4, 1'b1);
        handshake_a("maj4");

        // Scenario 5: reset in the 4th SETTLE aborts immediately
        bus_a.req_challenge = 8'hC3;
        bus_a.req_valid     = 1'b1;
        @(posedge clk);
        #1;
        bus_a.req_valid = 1'b0;
        repeat (63) @(posedge clk);
        #1;
        check("s5 in settle before reset", 32'(puf_start_a), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("s5 async puf_challenge", 32'(puf_challenge_a), 32'h0);
        check("s5 async puf_start", 32'(puf_start_a), 32'd0);
        check("s5 async puf_reset", 32'(puf_reset_a), 32'd0);
        check("s5 async resp_valid", 32'(bus_a.resp_valid), 32'd0);
        check("s5 async resp_ones", 32'(bus_a.resp_ones), 32'd0);
        check("s5 async req_ready", 32'(bus_a.req_ready), 32'd1);
        check("s5 async busy", 32'(busy_a), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("s5 no stale resp_valid", 32'(bus_a.resp_valid), 32'd0);
        run_eval("s5", 8'h0F, 7'b1111111, 1'b0, 7, 1'b1);
        handshake_a("s5");

        // Scenario 6: REPEAT=1, SETTLE_CYCLES=4 instance
        bus_b.req_challenge = 8'h66;
        bus_b.req_valid     = 1'b1;
        @(posedge clk);
        #1;
        bus_b.req_valid = 1'b0;
        check("s6 puf_challenge", 32'(puf_challenge_b), 32'h66);
        n = 0;
        while (!bus_b.resp_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("s6 latency", 32'(n), 32'(LAT_B));
        check("s6 resp_bit", 32'(bus_b.resp_bit), 32'd1);
        check("s6 resp_ones", 32'(bus_b.resp_ones), 32'd1);
        bus_b.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_b.resp_ready = 1'b0;
        check("s6 req_ready after handshake", 32'(bus_b.req_ready), 32'd1);
        check("s6 busy after handshake", 32'(busy_b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/puf_eval_ctrl.md
PUF_EVAL_CTRL -- requirements
Module: puf_eval_ctrl

Interface
REQ-001 The block SHALL have a parameter N, default 8: challenge width (number of arbiter PUF stages).
REQ-002 The block SHALL have a parameter SETTLE_CYCLES, default 16: clocks puf_start is held high per evaluation; legal values are >= 4.
REQ-003 The block SHALL have a parameter REPEAT, default 7: evaluations per challenge for majority vote; legal values are odd and >= 1.
REQ-004 The block SHALL have a derived parameter CW = $clog2(REPEAT+1), the width of the vote count.
REQ-005 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have port req_valid, input, 1 bit: challenge request valid.
REQ-008 The block SHALL have port req_ready, output, 1 bit: controller can accept a challenge.
REQ-009 The block SHALL have port req_challenge, input, N bits: challenge to evaluate.
REQ-010 The block SHALL have port puf_challenge, output, N bits: registered challenge driven to the PUF core.
REQ-011 The block SHALL have port puf_reset, output, 1 bit: clear pulse to the PUF core.
REQ-012 The block SHALL have port puf_start, output, 1 bit: launch level to the PUF core.
REQ-013 The block SHALL have port puf_out, input, 1 bit: PUF response, asynchronous to clk.
REQ-014 The block SHALL have port resp_valid, output, 1 bit: response available.
REQ-015 The block SHALL have port resp_ready, input, 1 bit: consumer accepts the response.
REQ-016 The block SHALL have port resp_bit, output, 1 bit: majority-voted response.
REQ-017 The block SHALL have port resp_ones, output, CW bits: number of evaluations that sampled 1.
REQ-018 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-019 puf_out SHALL pass through a 2-flop synchronizer (puf_sync) before any use.
REQ-020 The FSM SHALL have states IDLE, CLEAR, SETTLE, SAMPLE and RESP.
REQ-021 req_ready SHALL equal (state==IDLE); a request is accepted on the clock edge where req_valid && req_ready.
REQ-022 On acceptance: puf_challenge <= req_challenge; ones count and rep count <= 0; next state CLEAR.
REQ-023 CLEAR SHALL last exactly 2 cycles with puf_reset=1 and puf_start=0, then go to SETTLE.
REQ-024 SETTLE SHALL last exactly SETTLE_CYCLES cycles with puf_reset=0 and puf_start=1, then go to SAMPLE.
REQ-025 SAMPLE SHALL last 1 cycle with puf_start=1, and on its edge: ones += puf_sync; rep += 1.
REQ-026 From SAMPLE, the FSM SHALL go to RESP if the incremented rep == REPEAT, else to CLEAR (puf_start falls, giving the fresh rising edge the core needs).
REQ-027 Each evaluation SHALL take SETTLE_CYCLES+3 clocks; resp_valid SHALL rise exactly REPEAT*(SETTLE_CYCLES+3) clocks after the accept edge.
REQ-028 In RESP: resp_valid=1; resp_bit = (ones > REPEAT/2); resp_ones = ones; all three stable until handshake.
REQ-029 The FSM SHALL leave RESP on the edge where resp_valid && resp_ready, going to IDLE; no new request is accepted in that same cycle.
REQ-030 puf_challenge SHALL hold its value from acceptance until the next acceptance, and SHALL NOT change mid-evaluation.
REQ-031 req_valid while busy SHALL be ignored, and req_challenge changes while busy SHALL have no effect.
REQ-032 The ones counter SHALL NOT overflow (max REPEAT fits CW); the rep counter SHALL reset to 0 on acceptance only.
REQ-033 In IDLE and RESP: puf_start=0 and puf_reset=0.

Reset
REQ-034 While reset is high: state=IDLE, puf_challenge=0, puf_reset=0, puf_start=0, resp_valid=0, resp_bit=0, resp_ones=0, counters=0, synchronizer=0, busy=0, req_ready=1.
REQ-035 Reset asserted mid-evaluation or in RESP SHALL abort immediately, discard the pending response, and leave no stale resp_valid after release.
REQ-036 The first accept SHALL be possible on the first clock edge after reset deasserts.

Verification
REQ-037 Scenario 1 (N=8, SETTLE_CYCLES=16, REPEAT=7): model puf_out=1 always, send 8'hA5 -> resp_valid 133 clocks after accept; resp_bit=1, resp_ones=7; puf_challenge=8'hA5 throughout.
REQ-038 Scenario 2: model puf_out returns 1 on 3 of 7 evaluations -> resp_bit=0, resp_ones=3; 7 puf_start rising edges observed, each preceded by 2 cycles of puf_reset=1.
REQ-039 Scenario 3: hold resp_ready=0 for 20 cycles -> resp_valid, resp_bit and resp_ones stable, req_ready=0; then resp_ready=1 -> IDLE next cycle, req_ready=1.
REQ-040 Scenario 4: pulse req_valid with a new challenge 8'h3C during SETTLE -> ignored; puf_challenge unchanged.
REQ-041 Scenario 5: assert reset during the 4th SETTLE -> all outputs at reset values asynchronously; after release, accept 8'h0F -> full 133-cycle evaluation.
REQ-042 Scenario 6 (REPEAT=1, SETTLE_CYCLES=4): puf_out=1 -> resp_valid 7 clocks after accept, resp_bit=1, resp_ones=1.
